// File: rtl/lock_seq_ctrl.sv
// Four-button code-entry sequencer: captures a 4-press code, checks it,
// and times OPEN/FAIL/LOCKOUT. Optional code programming: LOCK_PROGRAM_EN.
//
// Ports:
//   clk       system clock
//   rst_n     async active-low reset
//   btn_pulse debounced one-cycle press pulses, bit i = button i
//   state_o   current state encoding
//   led       progress / status LEDs
//   unlocked  high in OPEN
//   alarm     high in LOCKOUT
//   fail_cnt  consecutive failed attempts
//   entry_cnt presses captured in this attempt
module lock_seq_ctrl #(
  parameter logic [7:0] CODE          = 8'hE4,
  parameter int         MAX_FAILS     = 3,
  parameter int         HOLD_TICKS    = 16,
  parameter int         LOCKOUT_TICKS = 32,
  parameter int         TIMEOUT_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_pulse,
  output logic [2:0] state_o,
  output logic [3:0] led,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] fail_cnt,
  output logic [2:0] entry_cnt
);

  localparam int MAX_A = (HOLD_TICKS > LOCKOUT_TICKS) ?
                         HOLD_TICKS : LOCKOUT_TICKS;
  localparam int MAX_DUR = (MAX_A > TIMEOUT_TICKS) ?
                           MAX_A : TIMEOUT_TICKS;
  localparam int TW = $clog2(MAX_DUR) + 1;

  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);
  localparam logic [2:0]    FAIL_MAX  = 3'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5,
    S_PROG    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    entry_q, entry_d;
  logic [2:0]    fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    slot_q, slot_d;
  logic [7:0]    code_q;

  logic          press_ok;
  logic [1:0]    press_val;
  logic [TW-1:0] timer_inc;
  logic [2:0]    fail_inc;
  logic [2:0]    slot_base;

  // Exactly one bit set; multi-bit chords are not presses.
  assign press_ok  = (|btn_pulse) &&
                     ~(|(btn_pulse & (btn_pulse - 4'd1)));
  // Encoder valid only for one-hot input.
  assign press_val = {btn_pulse[3] | btn_pulse[2],
                      btn_pulse[3] | btn_pulse[1]};
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
  assign fail_inc  = fail_q + 3'd1;
  assign slot_base = {entry_q[1:0], 1'b0};

`ifdef LOCK_PROGRAM_EN
  logic       prog_cmd;
  logic [7:0] code_d;

  assign prog_cmd = (btn_pulse == 4'b1111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) code_q <= CODE;
    else        code_q <= code_d;
  end
`else
  assign code_q = CODE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      fail_q  <= '0;
      timer_q <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    slot_d  = slot_q;
`ifdef LOCK_PROGRAM_EN
    code_d  = code_q;
`endif
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (press_ok) begin
          slot_d[1:0] = press_val;
          entry_d     = 3'd1;
          state_d     = S_ENTRY;
        end
      end
      S_ENTRY: begin
        // A press on the timeout cycle takes priority.
        if (press_ok) begin
          slot_d[slot_base +: 2] = press_val;
          entry_d = entry_q + 3'd1;
          timer_d = '0;
          if (entry_q == 3'd3) state_d = S_CHECK;
        end else if (timer_q == TO_LAST) begin
          state_d = S_IDLE;
          entry_d = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_CHECK: begin
        entry_d = '0;
        timer_d = '0;
        if (slot_q == code_q) begin
          state_d = S_OPEN;
          fail_d  = '0;
        end else begin
          fail_d  = fail_inc;
          state_d = (fail_inc == FAIL_MAX) ? S_LOCKOUT : S_FAIL;
        end
      end
      S_OPEN: begin
`ifdef LOCK_PROGRAM_EN
        if (prog_cmd) begin
          state_d = S_PROG;
          entry_d = '0;
          timer_d = '0;
        end else
`endif
        if (timer_q == HOLD_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_FAIL: begin
        if (timer_q == HOLD_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
          fail_d  = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
`ifdef LOCK_PROGRAM_EN
      S_PROG: begin
        if (press_ok) begin
          slot_d[slot_base +: 2] = press_val;
          entry_d = entry_q + 3'd1;
          timer_d = '0;
          if (entry_q == 3'd3) begin
            code_d  = {press_val, slot_q[5:0]};
            entry_d = '0;
            state_d = S_IDLE;
          end
        end else if (timer_q == TO_LAST) begin
          state_d = S_IDLE;
          entry_d = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        entry_d = '0;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    led = 4'b0000;
    case (state_q)
      S_ENTRY: begin
        case (entry_q)
          3'd1:    led = 4'b0001;
          3'd2:    led = 4'b0011;
          3'd3:    led = 4'b0111;
          3'd4:    led = 4'b1111;
          default: led = 4'b0000;
        endcase
      end
      S_CHECK:   led = 4'b1111;
      S_OPEN:    led = 4'b1111;
      S_FAIL:    led = 4'b1010;
      S_LOCKOUT: led = 4'b0101;
      S_PROG:    led = 4'b1001;
      default:   led = 4'b0000;
    endcase
  end

  assign state_o   = state_q;
  assign unlocked  = (state_q == S_OPEN);
  assign alarm     = (state_q == S_LOCKOUT);
  assign fail_cnt  = fail_q;
  assign entry_cnt = entry_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed self-checking bench for lock_seq_ctrl.
// Define LOCK_PROGRAM_EN to also exercise code programming.
module tb_lock_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_pulse;
  logic [2:0] state_o;
  logic [3:0] led;
  logic       unlocked;
  logic       alarm;
  logic [2:0] fail_cnt;
  logic [2:0] entry_cnt;

  int checks = 0;
  int failures = 0;
  int cnt;

  lock_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_pulse (btn_pulse),
    .state_o   (state_o),
    .led       (led),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .fail_cnt  (fail_cnt),
    .entry_cnt (entry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one pulse for one cycle; returns at the negedge after
  // the sampling edge.
  task automatic press(input logic [3:0] v);
    @(negedge clk);
    btn_pulse = v;
    @(negedge clk);
    btn_pulse = 4'b0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic good_code();
    press(4'b0001);
    press(4'b0010);
    press(4'b0100);
    press(4'b1000);
  endtask

  task automatic bad_code();
    repeat (4) press(4'b0001);
  endtask

  initial begin
    rst_n = 1'b0;
    btn_pulse = 4'b0000;
    idle(2);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_led", 32'(led), 0);
    chk("rst_unl", 32'(unlocked), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_fail", 32'(fail_cnt), 0);
    chk("rst_entry", 32'(entry_cnt), 0);
    rst_n = 1'b1;
    idle(1);

    // Correct code, presses spaced 3 cycles
    press(4'b0001);
    chk("ok_s1", 32'(state_o), 1);
    chk("ok_led1", 32'(led), 'h1);
    idle(1);
    press(4'b0010);
    chk("ok_led2", 32'(led), 'h3);
    idle(1);
    press(4'b0100);
    chk("ok_led3", 32'(led), 'h7);
    chk("ok_ent3", 32'(entry_cnt), 3);
    idle(1);
    press(4'b1000);
    chk("ok_check", 32'(state_o), 2);
    chk("ok_led4", 32'(led), 'hF);
    chk("ok_unl0", 32'(unlocked), 0);
    idle(1);
    chk("ok_open", 32'(state_o), 3);
    cnt = 0;
    repeat (20) begin
      if (unlocked) cnt++;
      @(negedge clk);
    end
    chk("ok_open_len", 32'(cnt), 16);
    chk("ok_idle", 32'(state_o), 0);
    chk("ok_idle_led", 32'(led), 0);

    // Wrong code
    bad_code();
    chk("bad_check", 32'(state_o), 2);
    idle(1);
    chk("bad_fail", 32'(state_o), 4);
    chk("bad_led", 32'(led), 'hA);
    chk("bad_fcnt", 32'(fail_cnt), 1);
    chk("bad_unl", 32'(unlocked), 0);
    cnt = 0;
    repeat (20) begin
      if (state_o == 3'd4) cnt++;
      @(negedge clk);
    end
    chk("bad_fail_len", 32'(cnt), 16);
    chk("bad_idle", 32'(state_o), 0);

    // Lockout: two more wrong attempts
    bad_code();
    idle(1);
    chk("lk_fail2", 32'(fail_cnt), 2);
    chk("lk_state2", 32'(state_o), 4);
    idle(20);
    bad_code();
    idle(1);
    chk("lk_state", 32'(state_o), 5);
    chk("lk_alarm", 32'(alarm), 1);
    chk("lk_fcnt", 32'(fail_cnt), 3);
    chk("lk_led", 32'(led), 'h5);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (alarm) cnt++;
      if (i == 4) chk("lk_ign_state", 32'(state_o), 5);
      if (i == 4) chk("lk_ign_entry", 32'(entry_cnt), 0);
      btn_pulse = (i == 3 || i == 10) ? 4'b0001 : 4'b0000;
      @(negedge clk);
    end
    btn_pulse = 4'b0000;
    chk("lk_len", 32'(cnt), 32);
    chk("lk_exit", 32'(state_o), 0);
    chk("lk_fclr", 32'(fail_cnt), 0);
    chk("lk_noq", 32'(entry_cnt), 0);

    // Timeout, with a press landing on the timeout cycle
    bad_code();
    idle(20);
    chk("to_fpre", 32'(fail_cnt), 1);
    press(4'b0001);
    idle(62);
    press(4'b0010);
    chk("to_win_s", 32'(state_o), 1);
    chk("to_win_e", 32'(entry_cnt), 2);
    idle(63);
    chk("to_edge_s", 32'(state_o), 1);
    idle(1);
    chk("to_idle", 32'(state_o), 0);
    chk("to_entry", 32'(entry_cnt), 0);
    chk("to_fail", 32'(fail_cnt), 1);
    press(4'b0011);
    chk("inv_3", 32'(state_o), 0);
    press(4'b1111);
    chk("inv_f", 32'(state_o), 0);
    chk("inv_ent", 32'(entry_cnt), 0);

    // Async reset mid-entry
    press(4'b0001);
    press(4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(state_o), 0);
    chk("ar_entry", 32'(entry_cnt), 0);
    chk("ar_fail", 32'(fail_cnt), 0);
    chk("ar_led", 32'(led), 0);
    idle(2);
    rst_n = 1'b1;
    good_code();
    idle(1);
    chk("ar_open", 32'(unlocked), 1);
    idle(20);
    chk("ar_idle", 32'(state_o), 0);

`ifdef LOCK_PROGRAM_EN
    good_code();
    idle(1);
    press(4'b1111);
    chk("pg_state", 32'(state_o), 6);
    chk("pg_led", 32'(led), 'h9);
    chk("pg_ent0", 32'(entry_cnt), 0);
    press(4'b1000);
    press(4'b1000);
    chk("pg_ent2", 32'(entry_cnt), 2);
    press(4'b0001);
    press(4'b0001);
    chk("pg_done", 32'(state_o), 0);
    good_code();
    idle(1);
    chk("pg_old", 32'(state_o), 4);
    idle(20);
    press(4'b1000);
    press(4'b1000);
    press(4'b0001);
    press(4'b0001);
    idle(1);
    chk("pg_new", 32'(state_o), 3);
    idle(20);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    good_code();
    idle(1);
    chk("pg_rst", 32'(state_o), 3);
    idle(20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
